snake_body_map: RTL
===================

// Module: snake_body_map
// PURPOSE
//  Game-state stage feeding the VGA pixel/colour stage. Holds snake segment coordinates on a 40x30 grid of 16x16 px cells.
//  Advances the snake one cell per move_tick, detects apple/wall/self hits, grows on eat.
//  Classifies the currently scanned pixel as NONE/HEAD/BODY/WALL for the colour stage, with zero latency.
// PARAMETERS
//  MAX_LEN    32  maximum segment count; length saturates here
//  INIT_LEN   3   segment count after reset/restart (2..MAX_LEN)
//  GRID_W     40  cells per row; x cell = x_pos[9:4]
//  GRID_H     30  cells per column; y cell = y_pos[9:4]
// PORTS
//  clk        in   1   system clock; the single clock domain
//  rst        in   1   asynchronous, active-high reset
//  restart    in   1   sync pulse: reload initial state, leave DEAD
//  move_tick  in   1   1-clk pulse at game speed
//  dir        in   2   requested direction: 00 UP, 01 DOWN, 10 LEFT, 11 RIGHT
//  apple_x    in   6   apple cell column
//  apple_y    in   5   apple cell row
//  x_pos      in   10  scanned pixel x, 0..639 visible
//  y_pos      in   10  scanned pixel y, 0..479 visible
//  snake      out  2   pixel class: 00 NONE, 01 HEAD, 10 BODY, 11 WALL
//  eat        out  1   1-clk pulse when head enters apple cell
//  dead       out  1   level; high from collision until restart/rst
//  length     out  6   current segment count
// BEHAVIOUR
//  Reset/restart:
//   head seg[0]=(20,15), seg[i]=(20-i,15) for i<INIT_LEN; length=INIT_LEN; cur_dir=RIGHT.
//   eat=0, dead=0, state=IDLE. Unused segs hold (0,0) and are masked by length.
//  restart has priority over move_tick in the same cycle.
//  FSM IDLE->CALC->CHECK->UPDATE->IDLE; a full move takes 3 clks after the tick.
//   IDLE: on move_tick go to CALC; move_tick in any other state is dropped.
//   CALC: latch dir into cur_dir unless it is the reverse of cur_dir (reverse ignored); compute nxt head.
//   CHECK: wall = nxt.x==0 | nxt.x==GRID_W-1 | nxt.y==0 | nxt.y==GRID_H-1.
//    grow = nxt==apple.
//    self = nxt==seg[i] for any i<length-1 (grow=0) or i<length (grow=1).
//    On wall|self -> DEAD; no segment change; eat stays 0. Otherwise -> UPDATE.
//   UPDATE: seg[i]<=seg[i-1] for i>=1, seg[0]<=nxt.
//    If grow: eat=1 for this cycle; length+1, saturating at MAX_LEN (at saturation no growth, eat still pulses).
//   DEAD: segments frozen; dead=1; leaves only on restart or rst.
//  Head arithmetic: 6/5-bit add/sub; the wall check precedes any use, so wrap is never committed.
//  Pixel class (combinational from x_pos/y_pos, same cycle; outputs registered elsewhere):
//   outside 640x480 -> NONE; border cell -> WALL.
//   cell==seg[0] -> HEAD; cell==seg[i], 0<i<length -> BODY; else NONE.
//   Priority WALL > HEAD > BODY > NONE. The apple is not classified here.
//  Class output uses the committed segments; during UPDATE it switches on the clk edge.
// STRUCTURE
//  Shared header: direction codes, class codes (NONE/HEAD/BODY/WALL), GRID_W/GRID_H, init head position.
//  Sub-module snake_cell_cmp: parallel compare of one (x,y) against seg[0..MAX_LEN-1] with a length mask.
//   Returns a hit vector; instance 1 serves the pixel path, instance 2 the CHECK path.
// TESTING
//  T1 rst, then tick x3 with dir=RIGHT -> head (23,15), tail (21,15), length=3, snake=HEAD at x_pos=368,y_pos=240.
//  T2 tick with dir=LEFT while cur_dir=RIGHT -> reversal ignored, head advances to x+1.
//  T3 apple at (21,15), one tick RIGHT -> eat pulses 1 clk in UPDATE; length=4; tail stays (18,15).
//  T4 drive head to x=38, tick RIGHT -> dead=1, segments unchanged; later ticks ignored; restart -> initial state.
//  T5 length 5, turn sequence UP, LEFT, DOWN -> self-hit, dead=1.
//   Moving into the tail cell with no growth is legal; dead stays 0.
//  T6 pixel sweep (0,0)->WALL; (639,479)->WALL; (640,0)->NONE; body cell->BODY. rst mid-UPDATE -> initial state immediately.

Source files
------------

// File: rtl/snake_body_map_pkg.sv
// Shared types and constants for the snake game-state stage: direction and pixel-class codes,
// grid geometry and the snake's starting position.
package snake_body_map_pkg;

  typedef enum logic [1:0] {
    DirUp    = 2'b00,
    DirDown  = 2'b01,
    DirLeft  = 2'b10,
    DirRight = 2'b11
  } dir_e;

  typedef enum logic [1:0] {
    ClsNone = 2'b00,
    ClsHead = 2'b01,
    ClsBody = 2'b10,
    ClsWall = 2'b11
  } cls_e;

  typedef enum logic [2:0] {
    StIdle,
    StCalc,
    StCheck,
    StUpdate,
    StDead
  } state_e;

  typedef struct packed {
    logic [5:0] x;
    logic [4:0] y;
  } cell_t;

  localparam int unsigned GridW = 40;
  localparam int unsigned GridH = 30;
  localparam logic [5:0] LastX = 6'(GridW - 1);
  localparam logic [4:0] LastY = 5'(GridH - 1);

  localparam logic [5:0] InitHeadX = 6'd20;
  localparam logic [4:0] InitHeadY = 5'd15;

  localparam logic [9:0] ScreenW = 10'd640;
  localparam logic [9:0] ScreenH = 10'd480;

  // Opposite directions differ only in bit 0 (UP/DOWN, LEFT/RIGHT).
  function automatic logic is_reverse(input dir_e a, input dir_e b);
    return (a ^ b) == 2'b01;
  endfunction

  // Wrap on the 6/5-bit fields is harmless: the wall check rejects it before commit.
  function automatic cell_t step_cell(input cell_t c, input dir_e d);
    cell_t n;
    n = c;
    case (d)
      DirUp:    n.y = c.y - 5'd1;
      DirDown:  n.y = c.y + 5'd1;
      DirLeft:  n.x = c.x - 6'd1;
      DirRight: n.x = c.x + 6'd1;
      default:  n = c;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/snake_cell_cmp.sv
// Parallel compare of one grid cell against every snake segment, masked to the first len_i
// segments; returns one hit bit per segment.
module snake_cell_cmp
  import snake_body_map_pkg::*;
#(
  parameter int unsigned MaxLen = 32
) (
  input  cell_t                cell_i,
  input  cell_t [MaxLen-1:0]   seg_i,
  input  logic  [5:0]          len_i,
  output logic  [MaxLen-1:0]   hit_o
);

  always_comb begin
    hit_o = '0;
    for (int i = 0; i < int'(MaxLen); i++) begin
      hit_o[i] = (seg_i[i] == cell_i) && (6'(i) < len_i);
    end
  end

endmodule

// File: rtl/snake_body_map.sv
// Snake game-state stage: moves the snake one cell per tick, detects apple/wall/self hits and
// classifies the scanned pixel as NONE/HEAD/BODY/WALL with zero latency.
module snake_body_map
  import snake_body_map_pkg::*;
#(
  parameter int unsigned MaxLen  = 32,
  parameter int unsigned InitLen = 3
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       restart_i,
  input  logic       move_tick_i,
  input  logic [1:0] dir_i,
  input  logic [5:0] apple_x_i,
  input  logic [4:0] apple_y_i,
  input  logic [9:0] x_pos_i,
  input  logic [9:0] y_pos_i,
  output logic [1:0] snake_o,
  output logic       eat_o,
  output logic       dead_o,
  output logic [5:0] length_o
);

  typedef cell_t [MaxLen-1:0] seg_arr_t;

  function automatic seg_arr_t init_segs();
    seg_arr_t s;
    for (int i = 0; i < int'(MaxLen); i++) begin
      if (i < int'(InitLen)) begin
        s[i] = cell_t'{x: InitHeadX - 6'(i), y: InitHeadY};
      end else begin
        s[i] = '0;
      end
    end
    return s;
  endfunction

  state_e   state_q, state_d;
  seg_arr_t seg_q, seg_d;
  logic [5:0] len_q, len_d;
  dir_e     cur_dir_q, cur_dir_d;
  cell_t    nxt_q, nxt_d;
  logic     grow_q, grow_d;

  dir_e  eff_dir;
  cell_t apple;
  logic  apple_hit, wall_hit, self_hit;
  logic [5:0] chk_len;
  logic [MaxLen-1:0] chk_hit;

  assign apple     = cell_t'{x: apple_x_i, y: apple_y_i};
  assign apple_hit = (nxt_q == apple);
  assign wall_hit  = (nxt_q.x == 6'd0) || (nxt_q.x == LastX) ||
                     (nxt_q.y == 5'd0) || (nxt_q.y == LastY);
  // Without growth the tail vacates its cell this move, so it is excluded.
  assign chk_len   = apple_hit ? len_q : 6'(len_q - 6'd1);
  assign self_hit  = |chk_hit;

  snake_cell_cmp #(
    .MaxLen (MaxLen)
  ) u_chk_cmp (
    .cell_i (nxt_q),
    .seg_i  (seg_q),
    .len_i  (chk_len),
    .hit_o  (chk_hit)
  );

  // FSM state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    if (restart_i) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle:   if (move_tick_i) state_d = StCalc;
        StCalc:   state_d = StCheck;
        StCheck:  state_d = (wall_hit || self_hit) ? StDead : StUpdate;
        StUpdate: state_d = StIdle;
        StDead:   state_d = StDead;
        default:  state_d = StIdle;
      endcase
    end
  end

  // Datapath next state
  always_comb begin
    seg_d     = seg_q;
    len_d     = len_q;
    cur_dir_d = cur_dir_q;
    nxt_d     = nxt_q;
    grow_d    = grow_q;
    eff_dir   = cur_dir_q;
    if (restart_i) begin
      seg_d     = init_segs();
      len_d     = 6'(InitLen);
      cur_dir_d = DirRight;
      nxt_d     = '0;
      grow_d    = 1'b0;
    end else begin
      case (state_q)
        StCalc: begin
          if (!is_reverse(dir_e'(dir_i), cur_dir_q)) begin
            eff_dir = dir_e'(dir_i);
          end
          cur_dir_d = eff_dir;
          nxt_d     = step_cell(seg_q[0], eff_dir);
        end
        StCheck: grow_d = apple_hit;
        StUpdate: begin
          seg_d = {seg_q[MaxLen-2:0], nxt_q};
          if (grow_q && (len_q < 6'(MaxLen))) begin
            len_d = len_q + 6'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      seg_q     <= init_segs();
      len_q     <= 6'(InitLen);
      cur_dir_q <= DirRight;
      nxt_q     <= '0;
      grow_q    <= 1'b0;
    end else begin
      seg_q     <= seg_d;
      len_q     <= len_d;
      cur_dir_q <= cur_dir_d;
      nxt_q     <= nxt_d;
      grow_q    <= grow_d;
    end
  end

  // FSM outputs
  always_comb begin
    eat_o  = (state_q == StUpdate) && grow_q;
    dead_o = (state_q == StDead);
  end

  assign length_o = len_q;

  // Pixel classification
  logic        pix_vis, pix_border;
  logic [5:0]  pix_cx, pix_cy;
  cell_t       pix_cell;
  logic [MaxLen-1:0] pix_hit;

  assign pix_vis    = (x_pos_i < ScreenW) && (y_pos_i < ScreenH);
  assign pix_cx     = x_pos_i[9:4];
  assign pix_cy     = y_pos_i[9:4];
  assign pix_border = (pix_cx == 6'd0) || (pix_cx == LastX) ||
                      (pix_cy == 6'd0) || (pix_cy == {1'b0, LastY});
  assign pix_cell   = cell_t'{x: pix_cx, y: pix_cy[4:0]};

  snake_cell_cmp #(
    .MaxLen (MaxLen)
  ) u_pix_cmp (
    .cell_i (pix_cell),
    .seg_i  (seg_q),
    .len_i  (len_q),
    .hit_o  (pix_hit)
  );

  always_comb begin
    snake_o = ClsNone;
    if (!pix_vis) begin
      snake_o = ClsNone;
    end else if (pix_border) begin
      snake_o = ClsWall;
    end else if (pix_hit[0]) begin
      snake_o = ClsHead;
    end else if (|pix_hit[MaxLen-1:1]) begin
      snake_o = ClsBody;
    end
  end

endmodule
